detect_sequencer: RTL and testbench

- Controller that drives an external Moore serial sequence detector (one input bit `w`, one output `z`) from a parallel pattern word.
- On `start` it clears the detector, then steps it once per cycle with the pattern bits, LSB first.
- After each step it samples `z`, counting hits and recording the index of the first hit.
- Sits between the board switch/key logic and the detector FSM, so a whole test word can be run through the detector without manual clocking.

---
 rtl/detect_sequencer.sv | 97 +++++++++
 tb/tb_detect_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/detect_sequencer.sv
// Runs a parallel pattern word, LSB first, through an external Moore sequence
// detector. Counts the steps after which the detector reports z=1 and records the first one.
module detect_sequencer #(
  parameter int unsigned LEN   = 16,
  parameter int unsigned CNT_W = 5
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             start,
  input  logic [LEN-1:0]   pattern,
  input  logic             z_in,
  output logic             det_clr,
  output logic             det_step,
  output logic             w_out,
  output logic             busy,
  output logic             done,
  output logic             hit_any,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] first_hit
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [LEN-1:0]   shreg;
  logic [CNT_W-1:0] idx;
  logic             sample_c;

  // State register
  always_ff @(posedge Clock) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_CLEAR;
      S_CLEAR: state_nxt = S_RUN;
      S_RUN:   if (idx == LAST_IDX) state_nxt = S_FLUSH;
      S_FLUSH: state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Controls are decoded from the registered state; only det_clr also follows Reset
  assign det_clr  = Reset || (state == S_CLEAR);
  assign det_step = (state == S_RUN);
  assign w_out    = (state == S_RUN) && shreg[0];
  assign busy     = (state == S_CLEAR) || (state == S_RUN) || (state == S_FLUSH);
  assign done     = (state == S_DONE);

  // z_in reflects the step taken on the previous edge, so the bit being scored is idx-1.
  // idx runs on to LEN in FLUSH, so the last bit is scored there with the same rule.
  assign sample_c = ((state == S_RUN) && (idx != '0)) || (state == S_FLUSH);

  // Shift register, step index and hit bookkeeping
  always_ff @(posedge Clock) begin
    if (Reset) begin
      shreg     <= '0;
      idx       <= '0;
      hit_any   <= 1'b0;
      hit_count <= '0;
      first_hit <= '0;
    end else if (state == S_CLEAR) begin
      shreg     <= pattern;
      idx       <= '0;
      hit_any   <= 1'b0;
      hit_count <= '0;
      first_hit <= '0;
    end else begin
      if (state == S_RUN) begin
        shreg <= shreg >> 1;
        idx   <= idx + CNT_W'(1);
      end
      if (sample_c && z_in) begin
        hit_count <= hit_count + CNT_W'(1);
        if (!hit_any) begin
          hit_any   <= 1'b1;
          first_hit <= idx - CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_detect_sequencer.sv
// Scoreboard bench for detect_sequencer: a behavioural run-length detector drives z_in,
// and expected results are computed directly from each pattern word.
module tb_detect_sequencer;

  localparam int unsigned LEN   = 16;
  localparam int unsigned CNT_W = 5;

  logic             Clock = 1'b0;
  logic             Reset = 1'b1;
  logic             start = 1'b0;
  logic [LEN-1:0]   pattern = '0;
  logic             z_in;
  logic             det_clr;
  logic             det_step;
  logic             w_out;
  logic             busy;
  logic             done;
  logic             hit_any;
  logic [CNT_W-1:0] hit_count;
  logic [CNT_W-1:0] first_hit;

  detect_sequencer #(.LEN(LEN), .CNT_W(CNT_W)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .start     (start),
    .pattern   (pattern),
    .z_in      (z_in),
    .det_clr   (det_clr),
    .det_step  (det_step),
    .w_out     (w_out),
    .busy      (busy),
    .done      (done),
    .hit_any   (hit_any),
    .hit_count (hit_count),
    .first_hit (first_hit)
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Detector: z=1 once the last four or more stepped bits are equal
  int   dlen = 0;
  logic dlast = 1'b0;
  always @(posedge Clock) begin
    if (det_clr) dlen <= 0;
    else if (det_step) begin
      if (dlen > 0 && w_out == dlast) dlen <= (dlen < 8) ? dlen + 1 : dlen;
      else dlen <= 1;
      dlast <= w_out;
    end
  end
  assign z_in = (dlen >= 4);

  typedef struct {
    logic [LEN-1:0] pat;
    int             cnt;
    int             first;
    int             any;
  } exp_t;

  exp_t sb[$];

  // Expected results straight from the bit string
  function automatic exp_t model(input logic [LEN-1:0] p);
    exp_t e;
    int   run;
    e.pat = p; e.cnt = 0; e.first = 0; e.any = 0;
    run = 0;
    for (int i = 0; i < int'(LEN); i++) begin
      if (i > 0 && p[i] == p[i-1]) run++;
      else run = 1;
      if (run >= 4) begin
        if (e.any == 0) begin
          e.any   = 1;
          e.first = i;
        end
        e.cnt++;
      end
    end
    return e;
  endfunction

  // Monitor: tracks each run from CLEAR and scores it when done appears
  int             cyc = 0;
  bit             in_run = 0;
  int             clr_cyc = 0;
  int             nsteps = 0;
  int             first_step = -1;
  logic [LEN-1:0] wseq = '0;

  always @(negedge Clock) begin
    exp_t e;
    cyc++;
    if (Reset) begin
      in_run = 0;
    end else begin
      if (busy && !in_run) begin
        in_run     = 1;
        clr_cyc    = cyc;
        nsteps     = 0;
        first_step = -1;
        wseq       = '0;
        chk("clear_det_clr", 32'(det_clr), 32'd1);
        chk("clear_no_step", 32'(det_step), 32'd0);
      end
      if (det_step) begin
        if (nsteps < int'(LEN)) wseq[nsteps] = w_out;
        if (first_step < 0) first_step = cyc;
        nsteps++;
      end
      if (done) begin
        if (!in_run || sb.size() == 0) begin
          chk("unexpected_done", 32'(done), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("hit_count", 32'(hit_count), 32'(e.cnt));
          chk("first_hit", 32'(first_hit), 32'(e.first));
          chk("hit_any", 32'(hit_any), 32'(e.any));
          chk("w_sequence", 32'(wseq), 32'(e.pat));
          chk("step_count", 32'(nsteps), 32'(LEN));
          chk("first_step_offset", 32'(first_step - clr_cyc), 32'd1);
          chk("done_latency", 32'(cyc - clr_cyc), 32'(LEN + 2));
          chk("done_not_busy", 32'(busy), 32'd0);
        end
        in_run = 0;
      end
    end
  end

  task automatic wait_done();
    bit seen;
    seen = 0;
    for (int i = 0; i < int'(LEN) + 10 && !seen; i++) begin
      @(negedge Clock);
      if (done === 1'b1) seen = 1;
    end
    chk("done_seen", 32'(seen), 32'd1);
  endtask

  task automatic run(input logic [LEN-1:0] p, input bit chg);
    @(posedge Clock); #1;
    pattern = p;
    start   = 1'b1;
    sb.push_back(model(p));
    @(posedge Clock); #1;
    start = 1'b0;
    if (chg) begin
      repeat ($urandom_range(1, LEN)) @(posedge Clock);
      #1 pattern = LEN'($urandom);
    end
    wait_done();
    @(posedge Clock); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset values
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    chk("rst_det_clr", 32'(det_clr), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_det_step", 32'(det_step), 32'd0);
    chk("rst_w_out", 32'(w_out), 32'd0);
    chk("rst_hit_any", 32'(hit_any), 32'd0);
    chk("rst_hit_count", 32'(hit_count), 32'd0);
    chk("rst_first_hit", 32'(first_hit), 32'd0);
    @(posedge Clock); #1;
    Reset = 1'b0;
    @(negedge Clock);
    chk("idle_det_clr", 32'(det_clr), 32'd0);

    // Directed patterns
    run(16'h0000, 0);
    run(16'h5555, 0);
    run(16'h00F0, 0);

    // Results are held in IDLE
    repeat (3) @(negedge Clock);
    chk("idle_hold_count", 32'(hit_count), 32'd7);
    chk("idle_hold_first", 32'(first_hit), 32'd3);

    // Start held through a whole run: exactly one extra run follows
    @(posedge Clock); #1;
    pattern = 16'hFFFF;
    start   = 1'b1;
    sb.push_back(model(16'hFFFF));
    wait_done();
    pattern = 16'h5555;
    sb.push_back(model(16'h5555));
    @(posedge Clock); #1;
    @(posedge Clock); #1;
    start = 1'b0;
    wait_done();
    repeat (LEN + 6) @(posedge Clock);
    #1;

    // Reset in cycle 8 of a run
    pattern = 16'h0000;
    start   = 1'b1;
    @(posedge Clock); #1;
    start = 1'b0;
    repeat (7) @(posedge Clock);
    #1;
    @(negedge Clock);
    chk("pre_abort_count", 32'(hit_count), 32'd2);
    chk("pre_abort_busy", 32'(busy), 32'd1);
    @(posedge Clock); #1;
    Reset = 1'b1;
    @(negedge Clock);
    chk("abort_det_clr", 32'(det_clr), 32'd1);
    @(posedge Clock); #1;
    Reset = 1'b0;
    @(negedge Clock);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_hit_count", 32'(hit_count), 32'd0);
    chk("abort_hit_any", 32'(hit_any), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_det_step", 32'(det_step), 32'd0);
    repeat (LEN + 6) @(posedge Clock);
    #1;
    run(16'h00F0, 0);

    // Random patterns, some changed mid-run
    for (int n = 0; n < 24; n++) run(LEN'($urandom), bit'($urandom_range(0, 1)));

    repeat (5) @(posedge Clock);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
